// File: rtl/serial_subtractor_6bit.sv
// Bit-serial LSB-first two's-complement subtractor (answer = input1 - input2 mod 2^N).
// Uses one borrow flop and one result bit per BUSY cycle, with valid/ready on both sides.
module serial_subtractor_6bit #(
  parameter int unsigned N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] answer,
  output logic         borrow_out,
  output logic         zero
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    res_q, res_d;
  logic            borrow_q, borrow_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    answer_q, answer_d;
  logic            borrow_out_q, borrow_out_d;
  logic            zero_q, zero_d;

  // Single-bit full subtractor on the current LSBs.
  logic         bit_a, bit_b, diff_bit, borrow_next;
  logic [N-1:0] res_shifted;

  always_comb begin
    bit_a       = a_q[0];
    bit_b       = b_q[0];
    diff_bit    = bit_a ^ bit_b ^ borrow_q;
    borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
    res_shifted = {diff_bit, res_q[N-1:1]};
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    answer_d     = answer_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d      = input1;
          b_d      = input2;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = StBusy;
        end
      end

      StBusy: begin
        a_d      = {1'b0, a_q[N-1:1]};
        b_d      = {1'b0, b_q[N-1:1]};
        res_d    = res_shifted;
        borrow_d = borrow_next;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          // Publish the full result on the same edge that the last bit is formed.
          answer_d     = res_shifted;
          borrow_out_d = borrow_next;
          zero_d       = (res_shifted == '0);
          cnt_d        = '0;
          state_d      = StDone;
        end
      end

      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      answer_q     <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      answer_q     <= answer_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
    end
  end

  assign answer     = answer_q;
  assign borrow_out = borrow_out_q;
  assign zero       = zero_q;

endmodule
